// File: rtl/cache_pkg.sv
// Shared constants, AXI response codes and FSM state type for the cache memory-side stages.
package cache_pkg;

    localparam int unsigned BYTE_BITS      = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned LINE_BYTES_DEF = 16;

    localparam int unsigned OFFSET_BITS    = $clog2(LINE_BYTES_DEF);
    localparam int unsigned WORD_BYTES     = DATA_WIDTH_DEF / BYTE_BITS;
    localparam int unsigned WORDS_PER_LINE = LINE_BYTES_DEF / WORD_BYTES;
    localparam int unsigned WORD_OFF_BITS  = $clog2(WORDS_PER_LINE);
    localparam int unsigned LINE_BITS      = LINE_BYTES_DEF * BYTE_BITS;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrXfer,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } axi_master_state_e;

endpackage

// File: rtl/cache_axi_line_master_if.sv
// AXI4-Lite bus between the line master and the memory slave.
interface cache_axi_line_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/cache_axi_line_master.sv
// Moves one whole cache line to or from memory as a sequence of single-beat AXI4-Lite
// transactions and reports completion with the assembled line and a merged response.
module cache_axi_line_master
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LINE_BYTES = LINE_BYTES_DEF,
    localparam int unsigned LINE_W    = LINE_BYTES * BYTE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_req_valid,
    output logic                  line_req_ready,
    input  logic                  line_req_we,
    input  logic [ADDR_WIDTH-1:0] line_req_addr,
    input  logic [LINE_W-1:0]     line_req_wdata,
    output logic                  line_done_valid,
    output logic [LINE_W-1:0]     line_done_rdata,
    output logic [1:0]            line_done_resp,
    cache_axi_line_master_if.master m
);

    localparam int unsigned WBYTES    = DATA_WIDTH / BYTE_BITS;
    localparam int unsigned NWORDS    = LINE_BYTES / WBYTES;
    localparam int unsigned OFF_BITS  = $clog2(LINE_BYTES);
    localparam int unsigned BSEL_BITS = $clog2(WBYTES);
    localparam int unsigned CNT_BITS  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [CNT_BITS-1:0]   LAST_WORD = CNT_BITS'(NWORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

    axi_master_state_e     state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LINE_W-1:0]     wline_q;
    logic [LINE_W-1:0]     rline_q;
    logic [1:0]            resp_q;
    logic                  req_ready_q;
    logic                  done_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;

    logic                  last_word;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0] word_wdata;

    assign last_word = (cnt_q == LAST_WORD);
    assign word_addr = base_q | (ADDR_WIDTH'(cnt_q) << BSEL_BITS);

    always_comb begin
        word_wdata = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (cnt_q == CNT_BITS'(k)) begin
                word_wdata = wline_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            base_q      <= '0;
            wline_q     <= '0;
            rline_q     <= '0;
            resp_q      <= OKAY;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && line_req_valid) begin
                        req_ready_q <= 1'b0;
                        base_q      <= line_req_addr & ~OFF_MASK;
                        wline_q     <= line_req_wdata;
                        cnt_q       <= '0;
                        resp_q      <= OKAY;
                        if (line_req_we) begin
                            state_q   <= StWrXfer;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StWrXfer: begin
                    // AW and W retire independently; a low valid means that channel is done.
                    if (m.awready) awvalid_q <= 1'b0;
                    if (m.wready)  wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m.awready) && (!wvalid_q || m.wready)) begin
                        state_q  <= StWrResp;
                        bready_q <= 1'b1;
                    end
                end
                StWrResp: begin
                    if (m.bvalid) begin
                        bready_q <= 1'b0;
                        if (resp_q == OKAY) resp_q <= m.bresp;
                        if (last_word) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            state_q   <= StWrXfer;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end
                    end
                end
                StRdAddr: begin
                    if (m.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdData;
                    end
                end
                StRdData: begin
                    if (m.rvalid) begin
                        rready_q <= 1'b0;
                        for (int k = 0; k < NWORDS; k++) begin
                            if (cnt_q == CNT_BITS'(k)) begin
                                rline_q[k*DATA_WIDTH +: DATA_WIDTH] <= m.rdata;
                            end
                        end
                        if (resp_q == OKAY) resp_q <= m.rresp;
                        if (last_word) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            state_q   <= StRdAddr;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign line_req_ready  = req_ready_q;
    assign line_done_valid = done_q;
    assign line_done_rdata = rline_q;
    assign line_done_resp  = resp_q;

    assign m.awvalid = awvalid_q;
    assign m.awaddr  = word_addr;
    assign m.awprot  = 3'b000;
    assign m.wvalid  = wvalid_q;
    assign m.wdata   = word_wdata;
    assign m.wstrb   = '1;
    assign m.bready  = bready_q;
    assign m.arvalid = arvalid_q;
    assign m.araddr  = word_addr;
    assign m.arprot  = 3'b000;
    assign m.rready  = rready_q;

endmodule

// File: doc/cache_axi_line_master.md
Name: cache_axi_line_master

Overview:
- Downstream memory-side stage of the direct-mapped cache.
- Accepts one whole-line command from the cache controller FSM:
  - refill: read LINE_BYTES from memory;
  - evict: write back LINE_BYTES to memory.
- Performs the transfer as WORDS_PER_LINE single-beat AXI4-Lite transactions, then returns the assembled line and a merged response in a one-cycle completion pulse.
- One line operation and one AXI transaction are in flight at a time.

Parameters:
ADDR_WIDTH, 32, AXI/line address width
DATA_WIDTH, 32, AXI data width = cache word width (32 or 64)
LINE_BYTES, 16, bytes per cache line (power of 2, >= DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
line_req_valid  in  1  line command valid
line_req_ready  out  1  block can accept a command (high only in IDLE)
line_req_we  in  1  1 = evict (write line), 0 = refill (read line)
line_req_addr  in  ADDR_WIDTH  line base address; low OFFSET_BITS ignored
line_req_wdata  in  LINE_BITS  evict data; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
line_done_valid  out  1  one-cycle completion pulse
line_done_rdata  out  LINE_BITS  refilled line (same word packing); holds until next refill
line_done_resp  out  2  first non-OKAY resp seen in the line, else OKAY
m_awvalid / m_awready  out / in  1  write address handshake
m_awaddr  out  ADDR_WIDTH  write address
m_awprot  out  3  constant 3'b000
m_wvalid / m_wready  out / in  1  write data handshake
m_wdata  out  DATA_WIDTH  write data
m_wstrb  out  DATA_WIDTH/8  constant all ones
m_bvalid / m_bready  in / out  1  write response handshake
m_bresp  in  2  write response
m_arvalid / m_arready  out / in  1  read address handshake
m_araddr  out  ADDR_WIDTH  read address
m_arprot  out  3  constant 3'b000
m_rvalid / m_rready  in / out  1  read data handshake
m_rdata  in  DATA_WIDTH  read data
m_rresp  in  2  read response

Behaviour:
- Reset (rst high at a clk edge, any state, including mid-transfer):
  - state IDLE; word counter 0; all VALID/READY outputs 0.
  - line_done_valid 0, line_done_resp 2'b00, line_done_rdata 0.
  - Any outstanding AXI transaction is abandoned; the slave is reset together with this block.
- States: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - line_req_ready=1.
  - On line_req_valid, latch: addr with offset bits zeroed, we, wdata. Clear word counter and the sticky resp.
  - Go to WR_XFER if we, else RD_ADDR.
- Address of word k = base + k*WORD_BYTES. The counter runs 0..WORDS_PER_LINE-1 and never wraps past the line.
- WR_XFER:
  - m_awvalid and m_wvalid assert together.
  - Each drops independently on its own handshake; aw and w may complete in the same or different cycles, in either order.
  - When both have completed, go to WR_RESP.
  - addr/data stay stable while valid.
- WR_RESP:
  - m_bready=1.
  - On bvalid, merge bresp into the sticky resp.
  - If last word, go to DONE; else increment counter and go to WR_XFER.
- RD_ADDR: m_arvalid=1; on arready, go to RD_DATA.
- RD_DATA:
  - m_rready=1.
  - On rvalid, write rdata into word k of the line buffer and merge rresp.
  - If last word, go to DONE; else increment counter and go to RD_ADDR.
- DONE:
  - line_done_valid=1 for exactly one cycle; line_req_ready=0; next state IDLE.
  - A new request is accepted no earlier than the cycle after DONE.
- Error merge: the sticky resp takes the first non-OKAY value and is not overwritten afterwards.
  - Remaining beats still execute; no abort on error.
  - Refill data is captured regardless of rresp.
- Unexpected bvalid/rvalid outside WR_RESP/RD_DATA: ignored, because ready is low.
- Latency with a zero-wait slave (ready high, response one cycle after address): accept at cycle 0, done pulse at cycle 2*WORDS_PER_LINE+1 (cycle 9 for 4 words), for both read and write.
- VALID never depends combinationally on READY. All outputs are registered or decoded from state only.

Decomposition:
- Shared package cache_pkg, holding:
  - BYTE_BITS and the derived constants OFFSET_BITS, WORD_BYTES, WORDS_PER_LINE, WORD_OFF_BITS, LINE_BITS;
  - AXI resp codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - axi_master_state_e enum.
- No sub-module: a single FSM plus word counter, line buffer and sticky resp register.

Test Plan:
- Refill, zero-wait slave, addr 0x1000_0014, memory words 0xA0..0xA3 -> ARADDR sequence 0x1000_0010/14/18/1C; rdata = {A3,A2,A1,A0}; resp 00; done at cycle 9.
- Evict with aw ready 3 cycles before w ready (and then the reverse) -> each VALID held until its own handshake; exactly one B per word; wdata word k correct; done once.
- Refill, word 2 returns SLVERR and word 3 returns DECERR -> all 4 beats performed; line_done_resp=2'b10; words 0,1,3 data correct.
- rst asserted during RD_DATA of word 1 -> next cycle all valids/readies 0, state IDLE, no done pulse; the next refill completes correctly.
- Back-to-back requests with line_req_valid held high -> second request accepted in the cycle after the done pulse; ready low during DONE; counter restarts at 0.
- Random ready/valid stall bench (0-5 cycles) over 100 mixed lines -> scoreboard matches memory model; no VALID drop before handshake.
